// File: rtl/synth_pkg.sv
// Shared types for the polyphonic voice mixer: waveform selector and mixer FSM states.
package synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW,
        WAVE_TRI,
        WAVE_PULSE
    } wave_t;

    typedef enum logic [1:0] {
        MIX_IDLE,
        MIX_SCAN,
        MIX_OUT
    } mix_state_t;

endpackage

// File: rtl/wave_lut_shaper.sv
// Combinational waveshaper: maps the top phase bits of one voice to a unipolar sample.
module wave_lut_shaper
    import synth_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic [SAMPLE_W-1:0] p,
    input  wave_t               wave,
    output logic [SAMPLE_W-1:0] sample
);

    always_comb begin
        sample = '0;
        case (wave)
            WAVE_SQUARE: sample = p[SAMPLE_W-1] ? '1 : '0;
            WAVE_SAW:    sample = p;
            WAVE_TRI:    sample = p[SAMPLE_W-1] ? ~(p << 1) : (p << 1);
            WAVE_PULSE:  sample = (p[SAMPLE_W-1 -: 2] == 2'b00) ? '1 : '0;
            default:     sample = '0;
        endcase
    end

endmodule

// File: rtl/poly_voice_mixer.sv
// N-voice NCO bank, time-multiplexed averaging mixer and wrap-synchronised PWM output.
module poly_voice_mixer
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES    = 4,
    parameter int unsigned PHASE_W       = 16,
    parameter int unsigned SAMPLE_W      = 8,
    parameter int unsigned SAMPLE_PERIOD = 256
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          en,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic [NUM_VOICES*PHASE_W-1:0] freq_word,
    input  logic [NUM_VOICES*2-1:0]       wave_sel,
    output logic [SAMPLE_W-1:0]           sample_o,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          pwm_o
);

    localparam int unsigned LOG2N  = $clog2(NUM_VOICES);
    localparam int unsigned IDX_W  = (NUM_VOICES > 1) ? LOG2N : 1;
    localparam int unsigned ACC_W  = SAMPLE_W + LOG2N;
    localparam int unsigned TICK_W = $clog2(SAMPLE_PERIOD);

    if ((NUM_VOICES == 0) || ((NUM_VOICES & (NUM_VOICES - 1)) != 0)) begin : g_bad_voices
        $error("poly_voice_mixer: NUM_VOICES must be a power of 2");
    end
    if (SAMPLE_PERIOD < NUM_VOICES + 3) begin : g_bad_period
        $error("poly_voice_mixer: SAMPLE_PERIOD must be >= NUM_VOICES+3");
    end
    if ((SAMPLE_W > PHASE_W) || (SAMPLE_W < 2)) begin : g_bad_width
        $error("poly_voice_mixer: SAMPLE_W must be in 2..PHASE_W");
    end

    logic [PHASE_W-1:0]  phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]  phase_d [NUM_VOICES];
    logic [SAMPLE_W-1:0] snap_p_q [NUM_VOICES];
    logic [SAMPLE_W-1:0] snap_p_d [NUM_VOICES];
    wave_t               snap_wave_q [NUM_VOICES];
    wave_t               snap_wave_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] snap_en_q, snap_en_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SAMPLE_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SAMPLE_W-1:0] duty_q, duty_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    mix_state_t          state_q, state_d;

    logic                tick;
    logic [SAMPLE_W-1:0] shaped;
    logic [SAMPLE_W-1:0] voice_sample;

    wave_lut_shaper #(.SAMPLE_W(SAMPLE_W)) u_shaper (
        .p      (snap_p_q[idx_q]),
        .wave   (snap_wave_q[idx_q]),
        .sample (shaped)
    );

    // Gated-off voices add zero yet still count in the fixed divisor.
    assign voice_sample = snap_en_q[idx_q] ? shaped : '0;
    assign tick         = en && (tick_cnt_q == TICK_W'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                phase_q[v]     <= '0;
                snap_p_q[v]    <= '0;
                snap_wave_q[v] <= WAVE_SQUARE;
            end
            snap_en_q  <= '0;
            tick_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            acc_q      <= '0;
            idx_q      <= '0;
            state_q    <= MIX_IDLE;
        end else begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                phase_q[v]     <= phase_d[v];
                snap_p_q[v]    <= snap_p_d[v];
                snap_wave_q[v] <= snap_wave_d[v];
            end
            snap_en_q  <= snap_en_d;
            tick_cnt_q <= tick_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = MIX_IDLE;
        end else begin
            case (state_q)
                MIX_IDLE: if (tick) state_d = MIX_SCAN;
                MIX_SCAN: if (idx_q == IDX_W'(NUM_VOICES - 1)) state_d = MIX_OUT;
                MIX_OUT:  state_d = MIX_IDLE;
                default:  state_d = MIX_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            phase_d[v]     = phase_q[v];
            snap_p_d[v]    = snap_p_q[v];
            snap_wave_d[v] = snap_wave_q[v];
            if (en && voice_en[v]) begin
                phase_d[v] = phase_q[v] + freq_word[v*PHASE_W +: PHASE_W];
            end
        end
        snap_en_d  = snap_en_q;
        tick_cnt_d = tick_cnt_q;
        pwm_cnt_d  = pwm_cnt_q;
        duty_d     = duty_q;
        sample_d   = sample_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        valid_d    = en && (state_q == MIX_OUT);

        if (!en) begin
            acc_d = '0;
        end else begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
            // Duty only reloads at the period boundary so each PWM period is whole.
            pwm_cnt_d = pwm_cnt_q + SAMPLE_W'(1);
            if (pwm_cnt_q == '1) begin
                duty_d = sample_q;
            end
            case (state_q)
                MIX_IDLE: begin
                    if (tick) begin
                        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                            snap_p_d[v]    = phase_q[v][PHASE_W-1 -: SAMPLE_W];
                            snap_wave_d[v] = wave_t'(wave_sel[v*2 +: 2]);
                        end
                        snap_en_d = voice_en;
                        acc_d     = '0;
                        idx_d     = '0;
                    end
                end
                MIX_SCAN: begin
                    acc_d = acc_q + ACC_W'(voice_sample);
                    idx_d = idx_q + IDX_W'(1);
                end
                MIX_OUT:  sample_d = SAMPLE_W'(acc_q >> LOG2N);
                default:  acc_d = '0;
            endcase
        end
    end

    always_comb begin
        busy         = (state_q == MIX_SCAN) || (state_q == MIX_OUT);
        sample_o     = sample_q;
        sample_valid = valid_q;
        pwm_o        = en && (pwm_cnt_q < duty_q);
    end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Randomised directed bench for poly_voice_mixer against a cycle-level arithmetic reference.
module tb_poly_voice_mixer;

    localparam int N   = 4;
    localparam int PW  = 16;
    localparam int SW  = 8;
    localparam int SP  = 256;
    localparam int MAXS = (1 << SW) - 1;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            en;
    logic [N-1:0]    voice_en;
    logic [N*PW-1:0] freq_word;
    logic [N*2-1:0]  wave_sel;
    logic [SW-1:0]   sample_o;
    logic            sample_valid;
    logic            busy;
    logic            pwm_o;

    int tests = 0;
    int fails = 0;

    // Reference state
    int unsigned m_ph [N];
    int unsigned m_tcnt, m_pcnt, m_duty, m_samp;
    bit          m_valid, m_pend;
    int          m_rem, m_val;
    longint      cyc = 0;
    longint      tick_cyc = -1;
    int          dut_valids, mdl_valids, pwm_hi;

    poly_voice_mixer #(
        .NUM_VOICES   (N),
        .PHASE_W      (PW),
        .SAMPLE_W     (SW),
        .SAMPLE_PERIOD(SP)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en),
        .voice_en     (voice_en),
        .freq_word    (freq_word),
        .wave_sel     (wave_sel),
        .sample_o     (sample_o),
        .sample_valid (sample_valid),
        .busy         (busy),
        .pwm_o        (pwm_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int shape(input int unsigned ph, input int w);
        int p;
        p = int'(ph >> (PW - SW));
        case (w)
            0: return (p >= 128) ? MAXS : 0;
            1: return p;
            2: return (p < 128) ? 2 * p : 511 - 2 * p;
            default: return (p < 64) ? MAXS : 0;
        endcase
    endfunction

    function automatic int mix_now();
        int sum = 0;
        for (int v = 0; v < N; v++)
            if (voice_en[v]) sum += shape(m_ph[v], int'(wave_sel[v*2 +: 2]));
        return sum / N;
    endfunction

    task automatic rand_inputs();
        voice_en  = N'($urandom);
        freq_word = {$urandom, $urandom};
        wave_sel  = (N*2)'($urandom);
    endtask

    task automatic step();
        bit nv;
        nv = 1'b0;
        if (!n_rst) begin
            for (int v = 0; v < N; v++) m_ph[v] = 0;
            m_tcnt = 0; m_pcnt = 0; m_duty = 0; m_samp = 0; m_pend = 1'b0;
        end else if (!en) begin
            m_pend = 1'b0;
        end else begin
            if (m_pcnt == MAXS) m_duty = m_samp;
            if (m_pend) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_pend = 1'b0;
                    m_samp = m_val;
                    nv = 1'b1;
                end
            end
            if (m_tcnt == SP - 1) begin
                m_pend   = 1'b1;
                m_rem    = N + 1;
                m_val    = mix_now();
                tick_cyc = cyc;
            end
            for (int v = 0; v < N; v++)
                if (voice_en[v]) m_ph[v] = (m_ph[v] + freq_word[v*PW +: PW]) % 65536;
            m_tcnt = (m_tcnt + 1) % SP;
            m_pcnt = (m_pcnt + 1) % (MAXS + 1);
        end
        m_valid = nv;
        @(posedge clk);
        #1;
        cyc++;
        if (m_valid) mdl_valids++;
        if (sample_valid === 1'b1) begin
            dut_valids++;
            chk("valid_latency", 32'(cyc - tick_cyc), 32'(N + 2));
        end
        if (pwm_o === 1'b1) pwm_hi++;
        chk("sample_o", 32'(sample_o), 32'(m_samp));
        chk("sample_valid", 32'(sample_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("pwm_o", 32'(pwm_o), 32'(en && (m_pcnt < m_duty)));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pend(input string tag, input int rem_want);
        int k = 0;
        while (!(m_pend && m_rem == rem_want) && k < 2 * SP) begin
            step();
            k++;
        end
        chk(tag, 32'(m_pend && m_rem == rem_want), 32'd1);
    endtask

    initial begin
        n_rst = 1'b0;
        en    = 1'b1;
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
        end
        n_rst = 1'b1;

        // Saw on voice 0 only, +1 step of p per cycle
        rand_inputs();
        voice_en = 4'b0001;
        freq_word[0 +: PW] = 16'h0100;
        wave_sel[1:0] = 2'd1;
        dut_valids = 0; mdl_valids = 0;
        run(3 * SP);
        chk("saw_valid_count", 32'(dut_valids), 32'(mdl_valids));

        // Square on all voices with phases parked at 0x8000
        voice_en = '1;
        wave_sel = '0;
        for (int v = 0; v < N; v++)
            freq_word[v*PW +: PW] = PW'((32'h8000 - m_ph[v]) & 32'hFFFF);
        step();
        freq_word = '0;
        run(3 * SP);
        chk("square_sample", 32'(sample_o), 32'(MAXS));
        while (m_pcnt != 0) step();
        pwm_hi = 0;
        run(256);
        chk("square_pwm_high", 32'(pwm_hi), 32'(MAXS));

        // Inputs churn every cycle, including during scans
        for (int i = 0; i < 4 * SP; i++) begin
            rand_inputs();
            step();
        end

        // en drop mid-scan
        rand_inputs();
        voice_en = '1;
        wait_pend("wait_scan", 3);
        en = 1'b0;
        dut_valids = 0; pwm_hi = 0;
        run(20);
        chk("en_off_valids", 32'(dut_valids), 32'd0);
        chk("en_off_pwm", 32'(pwm_hi), 32'd0);
        en = 1'b1;
        dut_valids = 0; mdl_valids = 0;
        run(2 * SP);
        chk("reenable_valids", 32'(dut_valids), 32'(mdl_valids));

        // Random en toggling with random inputs
        for (int i = 0; i < 2 * SP; i++) begin
            rand_inputs();
            en = ($urandom_range(0, 9) != 0);
            step();
        end
        en = 1'b1;

        // Reset mid-scan
        wait_pend("wait_scan_rst", 2);
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        chk("rst_sample", 32'(sample_o), 32'd0);
        run(SP + 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
